// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: one outstanding block request,
// response matching, flush squash/drain and timeout retry.
module icache_refill_ctrl #(
  parameter int TAG_W   = 20,
  parameter int IDX_W   = 6,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   missValid_i,
  input  logic [TAG_W+IDX_W-1:0] missBlkAddr_i,
  input  logic                   flush_i,
  output logic                   ic2memReqValid_o,
  output logic [TAG_W+IDX_W-1:0] ic2memReqAddr_o,
  input  logic                   mem2icReqReady_i,
  input  logic                   mem2icRespValid_i,
  input  logic [TAG_W-1:0]       mem2icTag_i,
  input  logic [IDX_W-1:0]       mem2icIndex_i,
  input  logic [LINE_W-1:0]      mem2icData_i,
  output logic                   fillValid_o,
  output logic [TAG_W-1:0]       fillTag_o,
  output logic [IDX_W-1:0]       fillIndex_o,
  output logic [LINE_W-1:0]      fillData_o,
  output logic                   busy_o,
  output logic                   icMiss_o,
  output logic [7:0]             retryCnt_o
);

  localparam int AW = TAG_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0]     r_addr;
  logic [7:0]        r_ctr;
  logic [7:0]        r_retry;
  logic [TAG_W-1:0]  r_fillTag;
  logic [IDX_W-1:0]  r_fillIdx;
  logic [LINE_W-1:0] r_fillData;

  logic w_respHit;
  logic w_ctrDone;
  logic w_sameMiss;
  logic w_latch;
  logic w_capture;
  logic w_ctrClr;
  logic w_ctrInc;
  logic w_retryInc;
  logic w_miss;

  assign w_respHit  = mem2icRespValid_i &&
                      ({mem2icTag_i, mem2icIndex_i} == r_addr);
  assign w_ctrDone  = (r_ctr == 8'(TIMEOUT));
  assign w_sameMiss = missValid_i && !flush_i &&
                      (missBlkAddr_i == r_addr);

  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_capture  = 1'b0;
    w_ctrClr   = 1'b0;
    w_ctrInc   = 1'b0;
    w_retryInc = 1'b0;
    w_miss     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (missValid_i && !flush_i) begin
          w_latch = 1'b1;
          w_miss  = 1'b1;
          w_next  = S_REQ;
        end
      end
      S_REQ: begin
        if (mem2icReqReady_i) begin
          w_ctrClr = 1'b1;
          w_next   = flush_i ? S_DRAIN : S_WAIT;
        end else if (flush_i) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          w_ctrInc = !w_ctrDone;
          w_next   = S_DRAIN;
        end else if (w_respHit) begin
          w_capture = 1'b1;
          w_next    = S_FILL;
        end else if (w_ctrDone) begin
          w_retryInc = 1'b1;
          w_next     = S_REQ;
        end else begin
          w_ctrInc = 1'b1;
        end
      end
      S_FILL: begin
        w_next = S_IDLE;
      end
      S_DRAIN: begin
        // The orphan request is still live; a same-address miss adopts it.
        if (w_respHit) begin
          w_next = S_IDLE;
        end else if (w_sameMiss) begin
          w_miss = 1'b1;
          w_next = S_WAIT;
        end else if (w_ctrDone) begin
          w_next = S_IDLE;
        end else begin
          w_ctrInc = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_ctr      <= '0;
      r_retry    <= '0;
      r_fillTag  <= '0;
      r_fillIdx  <= '0;
      r_fillData <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) r_addr <= missBlkAddr_i;
      if (w_ctrClr) r_ctr <= '0;
      else if (w_ctrInc) r_ctr <= r_ctr + 8'd1;
      if (w_retryInc && r_retry != 8'hFF)
        r_retry <= r_retry + 8'd1;
      if (w_capture) begin
        r_fillTag  <= mem2icTag_i;
        r_fillIdx  <= mem2icIndex_i;
        r_fillData <= mem2icData_i;
      end
    end
  end

  assign ic2memReqValid_o = (r_state == S_REQ);
  assign ic2memReqAddr_o  = r_addr;
  assign fillValid_o      = (r_state == S_FILL);
  assign fillTag_o        = r_fillTag;
  assign fillIndex_o      = r_fillIdx;
  assign fillData_o       = r_fillData;
  assign busy_o           = (r_state != S_IDLE);
  assign icMiss_o         = w_miss && !reset;
  assign retryCnt_o       = r_retry;

endmodule
